// File: rtl/decode_stage_param.sv
// decode_stage_param
// Y86-64 pipelined decode stage. It holds the D pipeline register, the
// two-write-port register file, source/destination decode and the
// five-source operand forwarding network. It also flags load-use hazards
// so the external pipeline controller can act on them.
//
// Ports
//   clk, rst            clock; synchronous active-high reset
//   D_stall, D_bubble   D register hold / nop injection (bubble wins)
//   f_*                 fetched instruction fields from the fetch stage
//   e_/M_/W_dst*, val*  forwarding destinations and values from E/M/W
//   E_icode, E_dstM     instruction in execute, for load-use detection
//   d_*                 decoded fields and operands toward the E register
//   load_use            combinational load-use hazard flag
module decode_stage_param #(
    parameter int unsigned XLEN     = 64,
    parameter int unsigned NREG     = 15,
    parameter int unsigned RID_W    = 4,
    parameter int unsigned RSP_ID   = 4,
    parameter logic [3:0]  STAT_AOK = 4'd8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             D_stall,
    input  logic             D_bubble,
    input  logic [3:0]       f_icode,
    input  logic [3:0]       f_ifun,
    input  logic [RID_W-1:0] f_rA,
    input  logic [RID_W-1:0] f_rB,
    input  logic [3:0]       f_Stat,
    input  logic [XLEN-1:0]  f_valC,
    input  logic [XLEN-1:0]  f_valP,
    input  logic [RID_W-1:0] e_dstE,
    input  logic [RID_W-1:0] M_dstE,
    input  logic [RID_W-1:0] M_dstM,
    input  logic [RID_W-1:0] W_dstE,
    input  logic [RID_W-1:0] W_dstM,
    input  logic [XLEN-1:0]  e_valE,
    input  logic [XLEN-1:0]  M_valE,
    input  logic [XLEN-1:0]  m_valM,
    input  logic [XLEN-1:0]  W_valE,
    input  logic [XLEN-1:0]  W_valM,
    input  logic [3:0]       E_icode,
    input  logic [RID_W-1:0] E_dstM,
    output logic [3:0]       d_icode,
    output logic [3:0]       d_ifun,
    output logic [3:0]       d_Stat,
    output logic [XLEN-1:0]  d_valC,
    output logic [XLEN-1:0]  d_valA,
    output logic [XLEN-1:0]  d_valB,
    output logic [RID_W-1:0] d_srcA,
    output logic [RID_W-1:0] d_srcB,
    output logic [RID_W-1:0] d_dstE,
    output logic [RID_W-1:0] d_dstM,
    output logic             load_use
);

    typedef enum logic [3:0] {
        I_HALT   = 4'h0,
        I_NOP    = 4'h1,
        I_RRMOVQ = 4'h2,
        I_IRMOVQ = 4'h3,
        I_RMMOVQ = 4'h4,
        I_MRMOVQ = 4'h5,
        I_OPQ    = 4'h6,
        I_JXX    = 4'h7,
        I_CALL   = 4'h8,
        I_RET    = 4'h9,
        I_PUSHQ  = 4'hA,
        I_POPQ   = 4'hB
    } icode_e;

    localparam logic [RID_W-1:0] RNONE = '1;
    localparam logic [RID_W-1:0] RSP   = RID_W'(RSP_ID);

    // D pipeline register
    logic [3:0]       dIcode;
    logic [3:0]       dIfun;
    logic [RID_W-1:0] dRA;
    logic [RID_W-1:0] dRB;
    logic [XLEN-1:0]  dValC;
    logic [XLEN-1:0]  dValP;
    logic [3:0]       dStat;

    logic [XLEN-1:0]  regFile [NREG];
    logic [XLEN-1:0]  rfA;
    logic [XLEN-1:0]  rfB;
    logic             srcAValid;
    logic             srcBValid;

    always_ff @(posedge clk) begin
        if (rst || D_bubble) begin
            dIcode <= I_NOP;
            dIfun  <= '0;
            dRA    <= RNONE;
            dRB    <= RNONE;
            dValC  <= '0;
            dValP  <= '0;
            dStat  <= STAT_AOK;
        end else if (!D_stall) begin
            dIcode <= f_icode;
            dIfun  <= f_ifun;
            dRA    <= f_rA;
            dRB    <= f_rB;
            dValC  <= f_valC;
            dValP  <= f_valP;
            dStat  <= f_Stat;
        end
    end

    // Register file: the M port is checked first so it wins a same-register
    // collision. The RNONE guard only matters if NREG reaches 2^RID_W.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NREG; i++) begin
                regFile[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < NREG; i++) begin
                if (W_dstM != RNONE && W_dstM == RID_W'(i)) begin
                    regFile[i] <= W_valM;
                end else if (W_dstE != RNONE && W_dstE == RID_W'(i)) begin
                    regFile[i] <= W_valE;
                end
            end
        end
    end

    // Source and destination decode
    always_comb begin
        d_srcA = RNONE;
        d_srcB = RNONE;
        d_dstE = RNONE;
        d_dstM = RNONE;

        case (dIcode)
            I_RRMOVQ, I_RMMOVQ, I_OPQ, I_PUSHQ: d_srcA = dRA;
            I_RET, I_POPQ:                      d_srcA = RSP;
            default:                            d_srcA = RNONE;
        endcase

        case (dIcode)
            I_RMMOVQ, I_MRMOVQ, I_OPQ:          d_srcB = dRB;
            I_CALL, I_RET, I_PUSHQ, I_POPQ:     d_srcB = RSP;
            default:                            d_srcB = RNONE;
        endcase

        case (dIcode)
            I_RRMOVQ, I_IRMOVQ, I_OPQ:          d_dstE = dRB;
            I_CALL, I_RET, I_PUSHQ, I_POPQ:     d_dstE = RSP;
            default:                            d_dstE = RNONE;
        endcase

        case (dIcode)
            I_MRMOVQ, I_POPQ:                   d_dstM = dRA;
            default:                            d_dstM = RNONE;
        endcase
    end

    // Register file reads; RNONE and out-of-range IDs match no entry and read 0
    always_comb begin
        rfA = '0;
        rfB = '0;
        for (int unsigned i = 0; i < NREG; i++) begin
            if (d_srcA != RNONE && d_srcA == RID_W'(i)) begin
                rfA = regFile[i];
            end
            if (d_srcB != RNONE && d_srcB == RID_W'(i)) begin
                rfB = regFile[i];
            end
        end
    end

    // Forwarding: youngest producer first. W values are forwarded here
    // because the array only sees them after this edge.
    always_comb begin
        srcAValid = (d_srcA != RNONE);
        srcBValid = (d_srcB != RNONE);

        if (dIcode == I_JXX || dIcode == I_CALL) begin
            d_valA = dValP;
        end else if (srcAValid && d_srcA == e_dstE) begin
            d_valA = e_valE;
        end else if (srcAValid && d_srcA == M_dstM) begin
            d_valA = m_valM;
        end else if (srcAValid && d_srcA == M_dstE) begin
            d_valA = M_valE;
        end else if (srcAValid && d_srcA == W_dstM) begin
            d_valA = W_valM;
        end else if (srcAValid && d_srcA == W_dstE) begin
            d_valA = W_valE;
        end else begin
            d_valA = rfA;
        end

        if (srcBValid && d_srcB == e_dstE) begin
            d_valB = e_valE;
        end else if (srcBValid && d_srcB == M_dstM) begin
            d_valB = m_valM;
        end else if (srcBValid && d_srcB == M_dstE) begin
            d_valB = M_valE;
        end else if (srcBValid && d_srcB == W_dstM) begin
            d_valB = W_valM;
        end else if (srcBValid && d_srcB == W_dstE) begin
            d_valB = W_valE;
        end else begin
            d_valB = rfB;
        end
    end

    always_comb begin
        load_use = (E_icode == I_MRMOVQ || E_icode == I_POPQ) &&
                   (E_dstM != RNONE) &&
                   (E_dstM == d_srcA || E_dstM == d_srcB);
    end

    assign d_icode = dIcode;
    assign d_ifun  = dIfun;
    assign d_Stat  = dStat;
    assign d_valC  = dValC;

endmodule

// File: tb/tb_decode_stage_param.sv
// tb_decode_stage_param
// Self-checking bench for decode_stage_param: directed scenarios followed
// by randomized stimulus compared against a behavioural reference model.
module tb_decode_stage_param;

    logic        clk = 1'b0;
    logic        rst, D_stall, D_bubble;
    logic [3:0]  f_icode, f_ifun, f_rA, f_rB, f_Stat;
    logic [63:0] f_valC, f_valP;
    logic [3:0]  e_dstE, M_dstE, M_dstM, W_dstE, W_dstM;
    logic [63:0] e_valE, M_valE, m_valM, W_valE, W_valM;
    logic [3:0]  E_icode, E_dstM;
    logic [3:0]  d_icode, d_ifun, d_Stat;
    logic [63:0] d_valC, d_valA, d_valB;
    logic [3:0]  d_srcA, d_srcB, d_dstE, d_dstM;
    logic        load_use;

    int total = 0;
    int bad   = 0;

    // Reference model state
    logic [63:0] mRegs [15];
    logic [3:0]  mIcode, mIfun, mRA, mRB, mStat;
    logic [63:0] mValC, mValP;

    decode_stage_param #(
        .XLEN(64), .NREG(15), .RID_W(4), .RSP_ID(4), .STAT_AOK(4'd8)
    ) dut (
        .clk(clk), .rst(rst), .D_stall(D_stall), .D_bubble(D_bubble),
        .f_icode(f_icode), .f_ifun(f_ifun), .f_rA(f_rA), .f_rB(f_rB),
        .f_Stat(f_Stat), .f_valC(f_valC), .f_valP(f_valP),
        .e_dstE(e_dstE), .M_dstE(M_dstE), .M_dstM(M_dstM),
        .W_dstE(W_dstE), .W_dstM(W_dstM),
        .e_valE(e_valE), .M_valE(M_valE), .m_valM(m_valM),
        .W_valE(W_valE), .W_valM(W_valM),
        .E_icode(E_icode), .E_dstM(E_dstM),
        .d_icode(d_icode), .d_ifun(d_ifun), .d_Stat(d_Stat),
        .d_valC(d_valC), .d_valA(d_valA), .d_valB(d_valB),
        .d_srcA(d_srcA), .d_srcB(d_srcB), .d_dstE(d_dstE), .d_dstM(d_dstM),
        .load_use(load_use)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Decode rules, stated as opcode sets
    function automatic logic [3:0] expSrcA(input logic [3:0] ic, input logic [3:0] ra);
        if (ic inside {4'h2, 4'h4, 4'h6, 4'hA}) return ra;
        if (ic inside {4'h9, 4'hB}) return 4'd4;
        return 4'hF;
    endfunction

    function automatic logic [3:0] expSrcB(input logic [3:0] ic, input logic [3:0] rb);
        if (ic inside {4'h4, 4'h5, 4'h6}) return rb;
        if (ic inside {4'h8, 4'h9, 4'hA, 4'hB}) return 4'd4;
        return 4'hF;
    endfunction

    function automatic logic [3:0] expDstE(input logic [3:0] ic, input logic [3:0] rb);
        if (ic inside {4'h2, 4'h3, 4'h6}) return rb;
        if (ic inside {4'h8, 4'h9, 4'hA, 4'hB}) return 4'd4;
        return 4'hF;
    endfunction

    function automatic logic [3:0] expDstM(input logic [3:0] ic, input logic [3:0] ra);
        if (ic inside {4'h5, 4'hB}) return ra;
        return 4'hF;
    endfunction

    // Value for a source: first matching producer in age order, else the array
    function automatic logic [63:0] expOperand(input logic [3:0] src);
        logic [3:0]  ids  [5];
        logic [63:0] vals [5];
        ids  = '{e_dstE, M_dstM, M_dstE, W_dstM, W_dstE};
        vals = '{e_valE, m_valM, M_valE, W_valM, W_valE};
        if (src == 4'hF) return 64'd0;
        for (int i = 0; i < 5; i++) begin
            if (ids[i] == src) return vals[i];
        end
        return mRegs[src];
    endfunction

    task automatic modelEdge();
        if (rst) begin
            for (int i = 0; i < 15; i++) mRegs[i] = 64'd0;
        end else begin
            if (W_dstE < 4'd15) mRegs[W_dstE] = W_valE;
            if (W_dstM < 4'd15) mRegs[W_dstM] = W_valM;
        end
        if (rst || D_bubble) begin
            mIcode = 4'h1; mIfun = 4'h0; mRA = 4'hF; mRB = 4'hF;
            mValC = 64'd0; mValP = 64'd0; mStat = 4'd8;
        end else if (!D_stall) begin
            mIcode = f_icode; mIfun = f_ifun; mRA = f_rA; mRB = f_rB;
            mValC = f_valC; mValP = f_valP; mStat = f_Stat;
        end
    endtask

    task automatic checkAll();
        logic [3:0]  sa, sb;
        logic [63:0] va;
        logic        lu;
        sa = expSrcA(mIcode, mRA);
        sb = expSrcB(mIcode, mRB);
        va = (mIcode == 4'h7 || mIcode == 4'h8) ? mValP : expOperand(sa);
        lu = (E_icode == 4'h5 || E_icode == 4'hB) && E_dstM != 4'hF &&
             (E_dstM == sa || E_dstM == sb);
        checkVal("m_icode", 64'(d_icode), 64'(mIcode));
        checkVal("m_ifun",  64'(d_ifun),  64'(mIfun));
        checkVal("m_stat",  64'(d_Stat),  64'(mStat));
        checkVal("m_valC",  d_valC, mValC);
        checkVal("m_srcA",  64'(d_srcA), 64'(sa));
        checkVal("m_srcB",  64'(d_srcB), 64'(sb));
        checkVal("m_dstE",  64'(d_dstE), 64'(expDstE(mIcode, mRB)));
        checkVal("m_dstM",  64'(d_dstM), 64'(expDstM(mIcode, mRA)));
        checkVal("m_valA",  d_valA, va);
        checkVal("m_valB",  d_valB, expOperand(sb));
        checkVal("m_loadUse", 64'(load_use), 64'(lu));
    endtask

    task automatic step();
        @(posedge clk);
        modelEdge();
        #1;
        checkAll();
    endtask

    task automatic setIdle();
        rst = 1'b0; D_stall = 1'b0; D_bubble = 1'b0;
        f_icode = 4'h1; f_ifun = 4'h0; f_rA = 4'hF; f_rB = 4'hF; f_Stat = 4'd8;
        f_valC = 64'd0; f_valP = 64'd0;
        e_dstE = 4'hF; M_dstE = 4'hF; M_dstM = 4'hF; W_dstE = 4'hF; W_dstM = 4'hF;
        e_valE = 64'd0; M_valE = 64'd0; m_valM = 64'd0; W_valE = 64'd0; W_valM = 64'd0;
        E_icode = 4'h1; E_dstM = 4'hF;
    endtask

    function automatic logic [3:0] pickId();
        int unsigned r;
        r = $urandom_range(0, 9);
        if (r < 3) return 4'hF;
        if (r < 6) return 4'($urandom_range(0, 3));
        return 4'($urandom_range(0, 14));
    endfunction

    initial begin
        setIdle();
        for (int i = 0; i < 15; i++) mRegs[i] = 64'd0;
        mIcode = 4'h1; mIfun = 4'h0; mRA = 4'hF; mRB = 4'hF;
        mValC = 64'd0; mValP = 64'd0; mStat = 4'd8;

        // Reset
        rst = 1'b1;
        step();
        rst = 1'b0;
        checkVal("rst_icode", 64'(d_icode), 64'd1);
        checkVal("rst_stat",  64'(d_Stat),  64'd8);
        checkVal("rst_srcA",  64'(d_srcA),  64'd15);
        checkVal("rst_srcB",  64'(d_srcB),  64'd15);
        checkVal("rst_dstE",  64'(d_dstE),  64'd15);
        checkVal("rst_dstM",  64'(d_dstM),  64'd15);
        checkVal("rst_valA",  d_valA, 64'd0);
        checkVal("rst_valB",  d_valB, 64'd0);

        // Register write then read through OPq
        W_dstE = 4'd3; W_valE = 64'd2;
        step();
        W_dstE = 4'hF; W_valE = 64'd0;
        f_icode = 4'h6; f_rA = 4'd3; f_rB = 4'd3;
        step();
        checkVal("rf_valA", d_valA, 64'd2);
        checkVal("rf_valB", d_valB, 64'd2);
        checkVal("rf_dstE", 64'(d_dstE), 64'd3);

        // Forwarding priority on rrmovq
        f_icode = 4'h2; f_rA = 4'd3; f_rB = 4'd5;
        step();
        e_dstE = 4'd3; e_valE = 64'd7;
        M_dstE = 4'd3; M_valE = 64'd9;
        W_dstE = 4'd3; W_valE = 64'd11;
        #1;
        checkVal("fwd_e", d_valA, 64'd7);
        checkAll();
        e_dstE = 4'hF;
        #1;
        checkVal("fwd_M", d_valA, 64'd9);
        M_dstE = 4'hF;
        #1;
        checkVal("fwd_W", d_valA, 64'd11);
        checkAll();
        W_dstE = 4'hF;

        // call
        f_icode = 4'h8; f_rA = 4'hF; f_rB = 4'hF; f_valC = 64'd25; f_valP = 64'd23;
        step();
        checkVal("call_valA", d_valA, 64'd23);
        checkVal("call_srcB", 64'(d_srcB), 64'd4);
        checkVal("call_dstE", 64'(d_dstE), 64'd4);
        checkVal("call_valC", d_valC, 64'd25);

        // Load-use, stall, bubble
        f_icode = 4'h6; f_rA = 4'd11; f_rB = 4'hF; f_valC = 64'd0; f_valP = 64'd0;
        step();
        E_icode = 4'h5; E_dstM = 4'd11;
        #1;
        checkVal("lu_set", 64'(load_use), 64'd1);
        D_stall = 1'b1; f_icode = 4'h2; f_rA = 4'd1; f_valC = 64'd99;
        step();
        checkVal("stall_icode", 64'(d_icode), 64'd6);
        checkVal("stall_srcA",  64'(d_srcA),  64'd11);
        checkVal("stall_lu",    64'(load_use), 64'd1);
        D_stall = 1'b1; D_bubble = 1'b1;
        step();
        checkVal("bub_icode", 64'(d_icode), 64'd1);
        checkVal("bub_lu",    64'(load_use), 64'd0);
        D_stall = 1'b0; D_bubble = 1'b0; E_icode = 4'h1; E_dstM = 4'hF;

        // Writeback port collision
        f_icode = 4'h1; f_rA = 4'hF; f_rB = 4'hF;
        W_dstE = 4'd4; W_dstM = 4'd4; W_valE = 64'd5; W_valM = 64'd6;
        step();
        W_dstE = 4'hF; W_dstM = 4'hF;
        f_icode = 4'hB; f_rA = 4'd2;
        step();
        checkVal("wb_srcB", 64'(d_srcB), 64'd4);
        checkVal("wb_valB", d_valB, 64'd6);

        // Randomized phase
        for (int n = 0; n < 1500; n++) begin
            rst      = ($urandom_range(0, 99) == 0);
            D_bubble = ($urandom_range(0, 9) == 0);
            D_stall  = ($urandom_range(0, 5) == 0);
            f_icode  = 4'($urandom_range(0, 15));
            f_ifun   = 4'($urandom_range(0, 15));
            f_rA     = pickId();
            f_rB     = pickId();
            f_Stat   = 4'($urandom_range(0, 15));
            f_valC   = {$urandom, $urandom};
            f_valP   = {$urandom, $urandom};
            e_dstE   = pickId();
            M_dstE   = pickId();
            M_dstM   = pickId();
            W_dstE   = pickId();
            W_dstM   = pickId();
            e_valE   = {$urandom, $urandom};
            M_valE   = {$urandom, $urandom};
            m_valM   = {$urandom, $urandom};
            W_valE   = {$urandom, $urandom};
            W_valM   = {$urandom, $urandom};
            E_icode  = ($urandom_range(0, 1) == 0) ? 4'($urandom_range(4, 6)) : 4'hB;
            E_dstM   = pickId();
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
